// File: rtl/lsu_outstanding_cnt_if.sv
// ----------------------------------------------------------------------------
// lsu_outstanding_cnt_if
//   Bundles the LSU issue/retire events, the waitcnt request and the masks
//   returned to the issue arbiter for lsu_outstanding_cnt.
//   master : issue-stage side (drives events, receives masks)
//   slave  : the counter block
// Signals
//   lsu_valid/lsu_wfid           LSU op issued this cycle and its wavefront
//   lsu_done/lsu_done_wfid       LSU op retired this cycle and its wavefront
//   wc_valid/wc_wfid/wc_thr      waitcnt issued, its wavefront, its threshold
//   wc_wait_arry                 per-wavefront waitcnt stall mask
//   cnt_zero_arry                per-wavefront "no outstanding ops" mask
//   cnt_full_arry                per-wavefront "counter at max" mask
//   cnt_err                      sticky overflow/underflow flag
// ----------------------------------------------------------------------------
interface lsu_outstanding_cnt_if #(
  parameter int WF_PER_CU = 40,
  parameter int CNT_W     = 4
);
  logic                 lsu_valid;
  logic [5:0]           lsu_wfid;
  logic                 lsu_done;
  logic [5:0]           lsu_done_wfid;
  logic                 wc_valid;
  logic [5:0]           wc_wfid;
  logic [CNT_W-1:0]     wc_thr;
  logic [WF_PER_CU-1:0] wc_wait_arry;
  logic [WF_PER_CU-1:0] cnt_zero_arry;
  logic [WF_PER_CU-1:0] cnt_full_arry;
  logic                 cnt_err;

  modport master (
    output lsu_valid, lsu_wfid, lsu_done, lsu_done_wfid,
    output wc_valid, wc_wfid, wc_thr,
    input  wc_wait_arry, cnt_zero_arry, cnt_full_arry, cnt_err
  );

  modport slave (
    input  lsu_valid, lsu_wfid, lsu_done, lsu_done_wfid,
    input  wc_valid, wc_wfid, wc_thr,
    output wc_wait_arry, cnt_zero_arry, cnt_full_arry, cnt_err
  );
endinterface

// File: rtl/lsu_outstanding_cnt.sv
// ----------------------------------------------------------------------------
// lsu_outstanding_cnt
//   Per-wavefront count of outstanding LSU operations in the issue stage.
//   Produces a registered waitcnt stall mask, a zero-outstanding mask, an
//   optional counter-full mask and a sticky overflow/underflow flag.
// Ports
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous reset, active-low
//   bus  : lsu_outstanding_cnt_if.slave (events in, masks out)
// Configuration
//   LSU_OUTSTANDING_FULL_STALL_EN : when defined, cnt_full_arry decodes
//   counter == max; otherwise cnt_full_arry is tied to 0.
// ----------------------------------------------------------------------------
module lsu_outstanding_cnt #(
  parameter int WF_PER_CU = 40,
  parameter int CNT_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  lsu_outstanding_cnt_if.slave  bus
);
  localparam int               ID_W    = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]     cnt_q [WF_PER_CU];
  logic [CNT_W-1:0]     cnt_d [WF_PER_CU];
  logic [CNT_W-1:0]     thr_q [WF_PER_CU];
  logic [CNT_W-1:0]     thr_d [WF_PER_CU];
  logic [WF_PER_CU-1:0] wait_q, wait_d;
  logic                 err_q, err_d;

  logic [WF_PER_CU-1:0] inc, dec, wc_hit;

  // Ids >= WF_PER_CU never match any slot, so they are silently ignored.
  always_comb begin
    inc    = '0;
    dec    = '0;
    wc_hit = '0;
    for (int w = 0; w < WF_PER_CU; w++) begin
      inc[w]    = bus.lsu_valid && (bus.lsu_wfid      == ID_W'(w));
      dec[w]    = bus.lsu_done  && (bus.lsu_done_wfid == ID_W'(w));
      wc_hit[w] = bus.wc_valid  && (bus.wc_wfid       == ID_W'(w));
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    thr_d  = thr_q;
    wait_d = wait_q;
    err_d  = err_q;
    for (int w = 0; w < WF_PER_CU; w++) begin
      // Simultaneous issue and retire cancel out, even at 0 or max.
      case ({inc[w], dec[w]})
        2'b10: begin
          if (cnt_q[w] == CNT_MAX) err_d = 1'b1;
          else                     cnt_d[w] = cnt_q[w] + CNT_W'(1);
        end
        2'b01: begin
          if (cnt_q[w] == '0) err_d = 1'b1;
          else                cnt_d[w] = cnt_q[w] - CNT_W'(1);
        end
        default: ;
      endcase

      // Waitcnt and release both look at the post-event count so a retire
      // in the same cycle is already accounted for.
      if (wc_hit[w]) begin
        wait_d[w] = (cnt_d[w] > bus.wc_thr);
        if (cnt_d[w] > bus.wc_thr) thr_d[w] = bus.wc_thr;
      end else if (wait_q[w] && (cnt_d[w] <= thr_q[w])) begin
        wait_d[w] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < WF_PER_CU; w++) begin
        cnt_q[w] <= '0;
        thr_q[w] <= '0;
      end
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      thr_q  <= thr_d;
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  logic [WF_PER_CU-1:0] zero_arry, full_arry;

  always_comb begin
    zero_arry = '0;
    full_arry = '0;
    for (int w = 0; w < WF_PER_CU; w++) begin
      zero_arry[w] = (cnt_q[w] == '0);
`ifdef LSU_OUTSTANDING_FULL_STALL_EN
      full_arry[w] = (cnt_q[w] == CNT_MAX);
`else
      full_arry[w] = 1'b0;
`endif
    end
  end

  assign bus.wc_wait_arry  = wait_q;
  assign bus.cnt_zero_arry = zero_arry;
  assign bus.cnt_full_arry = full_arry;
  assign bus.cnt_err       = err_q;
endmodule

// File: tb/tb_lsu_outstanding_cnt.sv
// ----------------------------------------------------------------------------
// tb_lsu_outstanding_cnt
//   Directed scenarios followed by randomized traffic, all checked against a
//   behavioural model of per-wavefront integer counts, waits and thresholds.
// ----------------------------------------------------------------------------
module tb_lsu_outstanding_cnt;
  localparam int WF  = 40;
  localparam int CW  = 4;
  localparam int MAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_outstanding_cnt_if #(.WF_PER_CU(WF), .CNT_W(CW)) bus ();

  lsu_outstanding_cnt #(.WF_PER_CU(WF), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: plain integers per wavefront.
  int m_cnt  [WF];
  int m_thr  [WF];
  bit m_wait [WF];
  bit m_err;

  function automatic void model_reset();
    for (int w = 0; w < WF; w++) begin
      m_cnt[w] = 0; m_thr[w] = 0; m_wait[w] = 1'b0;
    end
    m_err = 1'b0;
  endfunction

  function automatic void model_step(bit lv, int lw, bit dv, int dw,
                                     bit wv, int ww, int wt);
    for (int w = 0; w < WF; w++) begin
      int n;
      n = m_cnt[w] + ((lv && lw == w) ? 1 : 0) - ((dv && dw == w) ? 1 : 0);
      if (n > MAX) begin n = MAX; m_err = 1'b1; end
      if (n < 0)   begin n = 0;   m_err = 1'b1; end
      m_cnt[w] = n;
      if (wv && ww == w) begin
        m_wait[w] = (n > wt);
        if (n > wt) m_thr[w] = wt;
      end else if (m_wait[w] && n <= m_thr[w]) begin
        m_wait[w] = 1'b0;
      end
    end
  endfunction

  function automatic logic [WF-1:0] exp_wait();
    logic [WF-1:0] v;
    for (int w = 0; w < WF; w++) v[w] = m_wait[w];
    return v;
  endfunction

  function automatic logic [WF-1:0] exp_zero();
    logic [WF-1:0] v;
    for (int w = 0; w < WF; w++) v[w] = (m_cnt[w] == 0);
    return v;
  endfunction

  function automatic logic [WF-1:0] exp_full();
    logic [WF-1:0] v;
    for (int w = 0; w < WF; w++) begin
`ifdef LSU_OUTSTANDING_FULL_STALL_EN
      v[w] = (m_cnt[w] == MAX);
`else
      v[w] = 1'b0;
`endif
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_wait"}, 64'(bus.wc_wait_arry),  64'(exp_wait()));
    chk({tag, "_zero"}, 64'(bus.cnt_zero_arry), 64'(exp_zero()));
    chk({tag, "_full"}, 64'(bus.cnt_full_arry), 64'(exp_full()));
    chk({tag, "_err"},  64'(bus.cnt_err),       64'(m_err));
  endtask

  task automatic cycle(input string tag, input bit lv, input int lw,
                       input bit dv, input int dw,
                       input bit wv, input int ww, input int wt);
    bus.lsu_valid     = lv;
    bus.lsu_wfid      = 6'(lw);
    bus.lsu_done      = dv;
    bus.lsu_done_wfid = 6'(dw);
    bus.wc_valid      = wv;
    bus.wc_wfid       = 6'(ww);
    bus.wc_thr        = 4'(wt);
    model_step(lv, lw, dv, dw, wv, ww, wt);
    @(posedge clk);
    #1;
    check_all(tag);
    bus.lsu_valid = 1'b0;
    bus.lsu_done  = 1'b0;
    bus.wc_valid  = 1'b0;
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [WF-1:0] all_ones;

  initial begin
    all_ones          = '1;
    bus.lsu_valid     = 1'b0;
    bus.lsu_wfid      = '0;
    bus.lsu_done      = 1'b0;
    bus.lsu_done_wfid = '0;
    bus.wc_valid      = 1'b0;
    bus.wc_wfid       = '0;
    bus.wc_thr        = '0;
    model_reset();

    // Reset state
    #12;
    chk("rst_wait", 64'(bus.wc_wait_arry),  64'(0));
    chk("rst_zero", 64'(bus.cnt_zero_arry), 64'(all_ones));
    chk("rst_full", 64'(bus.cnt_full_arry), 64'(0));
    chk("rst_err",  64'(bus.cnt_err),       64'(0));
    @(negedge clk);
    rst = 1'b1;

    // 1: waitcnt on wf5 and release by retires
    for (int i = 0; i < 3; i++) cycle("t1_iss", 1'b1, 5, 1'b0, 0, 1'b0, 0, 0);
    cycle("t1_wc", 1'b0, 0, 1'b0, 0, 1'b1, 5, 1);
    chk("t1_wait_set", 64'(bus.wc_wait_arry[5]), 64'(1));
    cycle("t1_ret1", 1'b0, 0, 1'b1, 5, 1'b0, 0, 0);
    chk("t1_wait_hold", 64'(bus.wc_wait_arry[5]), 64'(1));
    cycle("t1_ret2", 1'b0, 0, 1'b1, 5, 1'b0, 0, 0);
    chk("t1_wait_clr", 64'(bus.wc_wait_arry[5]), 64'(0));
    chk("t1_zero_no",  64'(bus.cnt_zero_arry[5]), 64'(0));
    cycle("t1_ret3", 1'b0, 0, 1'b1, 5, 1'b0, 0, 0);
    chk("t1_zero_yes", 64'(bus.cnt_zero_arry[5]), 64'(1));

    // 2: simultaneous issue/retire, then underflow
    cycle("t2_iss", 1'b1, 7, 1'b0, 0, 1'b0, 0, 0);
    cycle("t2_iss", 1'b1, 7, 1'b0, 0, 1'b0, 0, 0);
    cycle("t2_both", 1'b1, 7, 1'b1, 7, 1'b0, 0, 0);
    chk("t2_err_clean", 64'(bus.cnt_err), 64'(0));
    cycle("t2_ret", 1'b0, 0, 1'b1, 7, 1'b0, 0, 0);
    cycle("t2_ret", 1'b0, 0, 1'b1, 7, 1'b0, 0, 0);
    chk("t2_zero", 64'(bus.cnt_zero_arry[7]), 64'(1));
    cycle("t2_under", 1'b0, 0, 1'b1, 7, 1'b0, 0, 0);
    chk("t2_err_set", 64'(bus.cnt_err), 64'(1));
    idle("t2_idle");
    chk("t2_err_sticky", 64'(bus.cnt_err), 64'(1));

    // 3: saturation of wf0
    do_reset("t3_rst");
    for (int i = 0; i < 15; i++) cycle("t3_iss", 1'b1, 0, 1'b0, 0, 1'b0, 0, 0);
`ifdef LSU_OUTSTANDING_FULL_STALL_EN
    chk("t3_full", 64'(bus.cnt_full_arry[0]), 64'(1));
`else
    chk("t3_full", 64'(bus.cnt_full_arry[0]), 64'(0));
`endif
    chk("t3_err_clean", 64'(bus.cnt_err), 64'(0));
    cycle("t3_over", 1'b1, 0, 1'b0, 0, 1'b0, 0, 0);
    chk("t3_err_set", 64'(bus.cnt_err), 64'(1));
    // 15 retires bring it back to zero only if the count held at 15
    for (int i = 0; i < 15; i++) cycle("t3_ret", 1'b0, 0, 1'b1, 0, 1'b0, 0, 0);
    chk("t3_zero", 64'(bus.cnt_zero_arry[0]), 64'(1));

    // 4: waitcnt concurrent with last retire never stalls
    do_reset("t4_rst");
    cycle("t4_iss", 1'b1, 3, 1'b0, 0, 1'b0, 0, 0);
    cycle("t4_wc",  1'b0, 0, 1'b1, 3, 1'b1, 3, 0);
    chk("t4_nowait", 64'(bus.wc_wait_arry[3]), 64'(0));
    idle("t4_idle");
    chk("t4_nowait2", 64'(bus.wc_wait_arry[3]), 64'(0));

    // 5: out-of-range id ignored
    cycle("t5_iss", 1'b1, 45, 1'b0, 0, 1'b0, 0, 0);
    chk("t5_zero", 64'(bus.cnt_zero_arry), 64'(all_ones));
    chk("t5_err",  64'(bus.cnt_err), 64'(0));
    cycle("t5_ret", 1'b0, 0, 1'b1, 47, 1'b1, 44, 0);
    chk("t5_err2", 64'(bus.cnt_err), 64'(0));

    // 6: asynchronous reset while wf9 is waiting
    for (int i = 0; i < 4; i++) cycle("t6_iss", 1'b1, 9, 1'b0, 0, 1'b0, 0, 0);
    cycle("t6_wc", 1'b0, 0, 1'b0, 0, 1'b1, 9, 0);
    chk("t6_wait_set", 64'(bus.wc_wait_arry[9]), 64'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_wait", 64'(bus.wc_wait_arry),  64'(0));
    chk("t6_async_zero", 64'(bus.cnt_zero_arry), 64'(all_ones));
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle("t6_after");

    // Randomized traffic, with a reset every 100 cycles
    for (int i = 0; i < 400; i++) begin
      bit lv, dv, wv;
      int lw, dw, ww, wt;
      if (i % 100 == 0) do_reset("rnd_rst");
      lv = ($urandom_range(0, 9) < 6);
      dv = ($urandom_range(0, 9) < 4);
      wv = ($urandom_range(0, 3) == 0);
      lw = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 63) : $urandom_range(0, 5);
      dw = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 63) : $urandom_range(0, 5);
      ww = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 63) : $urandom_range(0, 5);
      wt = $urandom_range(0, 15);
      cycle("rnd", lv, lw, dv, dw, wv, ww, wt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
